asip_array_loader: RTL and testbench

Writer-side companion to the MAX/MIN/AVG ASIP datapath: accepts a byte stream over a valid/ready handshake, checks it, and writes the operand array into the processor's data memory. The memory layout it produces is element count at `BASE_ADDR`, then data bytes. On a clean load it pulses a start signal to the processor's control unit. It sits between the host/test interface and the memory write port, which it owns while `busy` is high.

---
 rtl/asip_array_loader_if.sv | 30 +++
 rtl/asip_array_loader.sv | 133 +++++++++++++
 tb/tb_asip_array_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asip_array_loader_if.sv
// Byte-stream input and memory write port of the ASIP array loader.
// Handshake: a byte moves on a rising edge where in_valid && in_ready; the source holds in_data stable while in_valid is high.
interface asip_array_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/asip_array_loader.sv
// Loads a length-prefixed, checksummed byte stream into ASIP data memory as
// (count at BASE_ADDR, data after it) and pulses done to start the processor.
module asip_array_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h20),
  parameter int                MAX_LEN   = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  asip_array_loader_if.slave  bus,
  input  logic                load_start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [7:0]          loaded_len,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        idx_q, idx_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        loaded_q, loaded_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rdy;
  logic              xfer;
  logic [7:0]        chk_sum;

  // The loader accepts bytes in every state that owns the stream; done/err are state decodes.
  assign rdy     = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign xfer    = bus.in_valid && rdy;
  assign chk_sum = acc_q + bus.in_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      len_q    <= 8'd0;
      idx_q    <= 8'd0;
      acc_q    <= 8'd0;
      loaded_q <= 8'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      loaded_q <= loaded_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    loaded_d = loaded_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (load_start) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          if ((bus.in_data == 8'd0) || (bus.in_data > MAX_LEN_B)) begin
            state_d = S_ERR;
          end else begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR;
            wdata_d = bus.in_data;
            len_d   = bus.in_data;
            idx_d   = 8'd1;
            acc_d   = bus.in_data;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          we_d    = 1'b1;
          addr_d  = BASE_ADDR + ADDR_W'(idx_q);
          wdata_d = bus.in_data;
          acc_d   = chk_sum;
          idx_d   = idx_q + 8'd1;
          if (idx_q == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        // The checksum byte is consumed but never written to memory.
        if (xfer) begin
          if (chk_sum == 8'd0) begin
            state_d  = S_DONE;
            loaded_d = len_q;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = rdy;
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign loaded_len    = loaded_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_asip_array_loader.sv
// Bench for asip_array_loader: directed and random loads checked against a
// stream-level model that predicts memory writes and the load outcome.
module tb_asip_array_loader;
  localparam int         ADDR_W  = 8;
  localparam logic [7:0] BASE    = 8'h20;
  localparam int         MAX_LEN = 16;

  typedef logic [7:0] byte_q_t[$];

  logic       CLK = 1'b0;
  logic       RESET;
  logic       load_start;
  logic       busy, done, err;
  logic [7:0] loaded_len;
  logic [2:0] state_dbg;

  asip_array_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

  asip_array_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_LEN(MAX_LEN)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .bus        (bus_if.slave),
    .load_start (load_start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .loaded_len (loaded_len),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [7:0]  exp_len = 8'h00;
  logic [15:0] exp_q[$];
  logic        xfer_q;

  always @(posedge CLK or posedge RESET)
    if (RESET) xfer_q <= 1'b0;
    else       xfer_q <= bus_if.in_valid && bus_if.in_ready;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (done) done_cnt++;
      if (bus_if.mem_we) begin
        logic [15:0] e;
        wr_cnt++;
        last_addr = bus_if.mem_addr;
        n_cmp++;
        if (!xfer_q) begin
          n_fail++;
          $display("FAIL write_follows_beat actual=no_beat addr=%0h required=beat", bus_if.mem_addr);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write actual=%0h:%0h required=none", bus_if.mem_addr, bus_if.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({bus_if.mem_addr, bus_if.mem_wdata} !== e) begin
            n_fail++;
            $display("FAIL write actual=%0h:%0h required=%0h:%0h",
                     bus_if.mem_addr, bus_if.mem_wdata, e[15:8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Stream = N, N data bytes, checksum. Valid N writes count + data; the
  // load succeeds when all N+2 bytes sum to zero mod 256.
  function automatic bit model_load(byte_q_t b);
    int n;
    int sum;
    n = b[0];
    if (n == 0 || n > MAX_LEN) return 1'b0;
    sum = 0;
    for (int i = 0; i <= n; i++) begin
      exp_q.push_back({8'(BASE + i), b[i]});
      sum += b[i];
    end
    return ((sum + b[n+1]) % 256) == 0;
  endfunction

  function automatic byte_q_t make_stream(int n, bit good);
    byte_q_t b;
    int      sum;
    b.push_back(8'(n));
    if (n == 0 || n > MAX_LEN) return b;
    sum = n;
    for (int i = 0; i < n; i++) begin
      b.push_back(8'($urandom_range(0, 255)));
      sum += b[i+1];
    end
    b.push_back(good ? 8'(256 - (sum % 256)) : 8'(257 - (sum % 256)));
    return b;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit st);
    int t = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = b;
    load_start      = st;
    while (!bus_if.in_ready && t < 50) begin
      step();
      t++;
    end
    n_cmp++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL ready_timeout actual=%0d required<50", t);
    end
    step();
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 8'($urandom_range(0, 255));
    load_start      = 1'b0;
  endtask

  task automatic run_load(input byte_q_t b, input int gap_mode, input int start_idx,
                          output logic o_done, output logic o_err, output logic o_rdy,
                          output logic [7:0] o_len, output logic o_done_next);
    foreach (b[i]) begin
      drive_byte(b[i], i == start_idx);
      if (i != b.size() - 1) begin
        if (gap_mode == 1) repeat (2) step();
        else if (gap_mode == 2) repeat ($urandom_range(0, 2)) step();
      end
    end
    o_done = done;
    o_err  = err;
    o_rdy  = bus_if.in_ready;
    o_len  = loaded_len;
    step();
    o_done_next = done;
  endtask

  // ---------------- tests ----------------
  logic       od, oe, ordy, odn;
  logic [7:0] olen;

  task automatic test_reset();
    RESET = 1'b1; load_start = 1'b0; bus_if.in_valid = 1'b0; bus_if.in_data = 8'h00;
    repeat (2) step();
    n_cmp++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready actual=%0h required=0", bus_if.in_ready); end
    n_cmp++; if (bus_if.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we actual=%0h required=0", bus_if.mem_we); end
    n_cmp++; if (bus_if.mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr actual=%0h required=0", bus_if.mem_addr); end
    n_cmp++; if (bus_if.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata actual=%0h required=0", bus_if.mem_wdata); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy actual=%0h required=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done actual=%0h required=0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err actual=%0h required=0", err); end
    n_cmp++; if (loaded_len !== 8'h00) begin n_fail++; $display("FAIL rst_loaded_len actual=%0h required=0", loaded_len); end
    RESET = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    byte_q_t b = '{8'h03, 8'h05, 8'h09, 8'h02, 8'hED};
    int d0 = done_cnt;
    bit ok = model_load(b);
    pulse_start();
    n_cmp++; if (bus_if.in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL nom_start_latency actual=%0h%0h required=11", bus_if.in_ready, busy); end
    run_load(b, 0, -1, od, oe, ordy, olen, odn);
    if (ok) exp_len = 8'h03;
    n_cmp++; if (od !== ok) begin n_fail++; $display("FAIL nom_done actual=%0h required=%0h", od, ok); end
    n_cmp++; if (oe !== 1'b0) begin n_fail++; $display("FAIL nom_err actual=%0h required=0", oe); end
    n_cmp++; if (olen !== exp_len) begin n_fail++; $display("FAIL nom_loaded_len actual=%0h required=%0h", olen, exp_len); end
    n_cmp++; if (odn !== 1'b0) begin n_fail++; $display("FAIL nom_done_width actual=%0h required=0", odn); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL nom_done_count actual=%0d required=1", done_cnt - d0); end
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL nom_writes_left actual=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_bad_checksum();
    byte_q_t b = '{8'h03, 8'h05, 8'h09, 8'h02, 8'h00};
    int d0 = done_cnt;
    bit ok = model_load(b);
    pulse_start();
    run_load(b, 0, -1, od, oe, ordy, olen, odn);
    n_cmp++; if (oe !== !ok) begin n_fail++; $display("FAIL bad_err actual=%0h required=%0h", oe, !ok); end
    n_cmp++; if (ordy !== 1'b0) begin n_fail++; $display("FAIL bad_in_ready actual=%0h required=0", ordy); end
    repeat (3) step();
    n_cmp++; if (err !== 1'b1 || bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL bad_sticky actual=%0h%0h required=10", err, bus_if.in_ready); end
    n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL bad_no_done actual=%0d required=%0d", done_cnt, d0); end
    n_cmp++; if (olen !== exp_len) begin n_fail++; $display("FAIL bad_loaded_len actual=%0h required=%0h", olen, exp_len); end
    pulse_start();
    n_cmp++; if (err !== 1'b0 || bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL bad_restart actual=%0h%0h required=01", err, bus_if.in_ready); end
    b = make_stream(5, 1'b1);
    ok = model_load(b);
    run_load(b, 0, -1, od, oe, ordy, olen, odn);
    if (ok) exp_len = 8'h05;
    n_cmp++; if (od !== 1'b1 || olen !== exp_len) begin n_fail++; $display("FAIL bad_recover actual=%0h/%0h required=1/%0h", od, olen, exp_len); end
  endtask

  task automatic test_length_limits();
    byte_q_t b;
    int w0;
    bit ok;
    b = make_stream(0, 1'b1);
    ok = model_load(b);
    w0 = wr_cnt;
    pulse_start();
    run_load(b, 0, -1, od, oe, ordy, olen, odn);
    n_cmp++; if (oe !== !ok || od !== 1'b0) begin n_fail++; $display("FAIL len0_err actual=%0h/%0h required=1/0", oe, od); end
    n_cmp++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL len0_writes actual=%0d required=0", wr_cnt - w0); end
    b = make_stream(MAX_LEN + 1, 1'b1);
    ok = model_load(b);
    pulse_start();
    run_load(b, 0, -1, od, oe, ordy, olen, odn);
    n_cmp++; if (oe !== !ok || ordy !== 1'b0) begin n_fail++; $display("FAIL len17_err actual=%0h/%0h required=1/0", oe, ordy); end
    n_cmp++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL len17_writes actual=%0d required=0", wr_cnt - w0); end
    b = make_stream(MAX_LEN, 1'b1);
    ok = model_load(b);
    pulse_start();
    run_load(b, 0, -1, od, oe, ordy, olen, odn);
    if (ok) exp_len = 8'(MAX_LEN);
    n_cmp++; if (od !== ok || olen !== exp_len) begin n_fail++; $display("FAIL len16_done actual=%0h/%0h required=%0h/%0h", od, olen, ok, exp_len); end
    n_cmp++; if (wr_cnt - w0 !== MAX_LEN + 1) begin n_fail++; $display("FAIL len16_writes actual=%0d required=%0d", wr_cnt - w0, MAX_LEN + 1); end
    n_cmp++; if (last_addr !== 8'h30) begin n_fail++; $display("FAIL len16_last_addr actual=%0h required=30", last_addr); end
  endtask

  task automatic test_gaps();
    byte_q_t b = '{8'h03, 8'h05, 8'h09, 8'h02, 8'hED};
    int w0 = wr_cnt;
    bit ok;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = 8'hAA;
    repeat (3) begin
      step();
      n_cmp++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready actual=%0h required=0", bus_if.in_ready); end
    end
    bus_if.in_valid = 1'b0;
    step();
    n_cmp++; if (wr_cnt !== w0) begin n_fail++; $display("FAIL idle_consumed actual=%0d required=0", wr_cnt - w0); end
    ok = model_load(b);
    pulse_start();
    run_load(b, 1, -1, od, oe, ordy, olen, odn);
    if (ok) exp_len = 8'h03;
    n_cmp++; if (od !== 1'b1 || oe !== 1'b0 || olen !== exp_len) begin n_fail++; $display("FAIL gap_result actual=%0h%0h/%0h required=10/%0h", od, oe, olen, exp_len); end
    n_cmp++; if (wr_cnt - w0 !== 4) begin n_fail++; $display("FAIL gap_writes actual=%0d required=4", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d0 = 8'($urandom_range(0, 255));
    logic [7:0] d1 = 8'($urandom_range(0, 255));
    byte_q_t    b;
    bit         ok;
    pulse_start();
    exp_q.push_back({BASE, 8'h05});
    exp_q.push_back({8'(BASE + 1), d0});
    exp_q.push_back({8'(BASE + 2), d1});
    drive_byte(8'h05, 1'b0);
    drive_byte(d0, 1'b0);
    drive_byte(d1, 1'b0);
    #1 RESET = 1'b1;
    #1;
    exp_len = 8'h00;
    n_cmp++; if (bus_if.mem_we !== 1'b0 || bus_if.mem_addr !== 8'h00 || bus_if.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL midrst_mem actual=%0h/%0h/%0h required=0/0/0", bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata); end
    n_cmp++; if (bus_if.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl actual=%0h%0h%0h%0h required=0000", bus_if.in_ready, busy, done, err); end
    n_cmp++; if (loaded_len !== exp_len) begin n_fail++; $display("FAIL midrst_loaded_len actual=%0h required=%0h", loaded_len, exp_len); end
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL midrst_writes actual=%0d required=0", exp_q.size()); end
    step();
    RESET = 1'b0;
    step();
    b = '{8'h03, 8'h05, 8'h09, 8'h02, 8'hED};
    ok = model_load(b);
    pulse_start();
    run_load(b, 0, -1, od, oe, ordy, olen, odn);
    if (ok) exp_len = 8'h03;
    n_cmp++; if (od !== 1'b1 || olen !== exp_len) begin n_fail++; $display("FAIL midrst_reload actual=%0h/%0h required=1/%0h", od, olen, exp_len); end
  endtask

  task automatic test_ignored_start();
    byte_q_t b;
    int      d0;
    bit      ok;
    // First run: start pulsed mid-DATA; second run: start on the final data byte.
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt;
      b  = make_stream(6, 1'b1);
      ok = model_load(b);
      pulse_start();
      run_load(b, 0, (k == 0) ? 3 : 6, od, oe, ordy, olen, odn);
      if (ok) exp_len = 8'h06;
      n_cmp++; if (od !== 1'b1 || oe !== 1'b0) begin n_fail++; $display("FAIL ign_result run=%0d actual=%0h%0h required=10", k, od, oe); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL ign_done_count run=%0d actual=%0d required=1", k, done_cnt - d0); end
      n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ign_writes_left run=%0d actual=%0d required=0", k, exp_q.size()); end
    end
  endtask

  task automatic test_random();
    byte_q_t b;
    int      n;
    int      d0;
    bit      ok;
    for (int k = 0; k < 12; k++) begin
      n  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) * 40 : $urandom_range(1, MAX_LEN);
      b  = make_stream(n, $urandom_range(0, 3) != 0);
      ok = model_load(b);
      d0 = done_cnt;
      pulse_start();
      run_load(b, 2, -1, od, oe, ordy, olen, odn);
      if (ok) exp_len = 8'(n);
      n_cmp++; if (od !== ok || oe !== !ok) begin n_fail++; $display("FAIL rnd_result k=%0d n=%0d actual=%0h%0h required=%0h%0h", k, n, od, oe, ok, !ok); end
      n_cmp++; if (olen !== exp_len) begin n_fail++; $display("FAIL rnd_loaded_len k=%0d actual=%0h required=%0h", k, olen, exp_len); end
      n_cmp++; if (done_cnt - d0 !== int'(ok)) begin n_fail++; $display("FAIL rnd_done_count k=%0d actual=%0d required=%0d", k, done_cnt - d0, ok); end
      n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rnd_writes_left k=%0d actual=%0d required=0", k, exp_q.size()); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_nominal();
    test_bad_checksum();
    test_length_limits();
    test_gaps();
    test_reset_mid();
    test_ignored_start();
    test_random();
    repeat (3) step();
    n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_writes_left actual=%0d required=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
